// File: rtl/rseq_pkg.sv
// rseq_pkg
//   Shared definitions for the interrupt/exception/IRET microsequencer:
//   FSM state encoding and the rseq ROM address map.
//     INTX : addresses 0..3 (push EFLAGS, push CS, push EIP, vector load)
//     IRET : addresses 4..6 (pop EIP, pop CS, pop EFLAGS)
//     address 7 is unused.
package rseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INTX = 2'd1,
    IRET = 2'd2,
    HALT = 2'd3
  } rseq_state_e;

  localparam logic [2:0] INTX_FIRST = 3'd0;
  localparam logic [2:0] INTX_LAST  = 3'd3;
  localparam logic [2:0] IRET_FIRST = 3'd4;
  localparam logic [2:0] IRET_LAST  = 3'd6;

endpackage

// File: rtl/rseq_ctrl.sv
// rseq_ctrl
//   Arbitrates exceptions, external interrupts and decoded IRETs, then steps
//   a 3-bit address through the rseq microcode ROM.
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   exc_req/exc_vec     pending exception and its vector (held until rseq_done)
//   int_req/int_vec     pending interrupt and its vector (held until int_ack)
//   if_flag             EFLAGS.IF
//   instr_boundary      decode sits at an instruction boundary
//   iret_req            IRET decoded
//   dec_ready           decode consumes the current ROM word this cycle
//   rseq_addr           ROM address
//   rseq_oe             ROM output enable
//   rseq_active         decode mux selects the ROM word
//   rseq_vec            vector latched for the current INTX sequence
//   rseq_is_exc         current sequence was started by an exception
//   int_ack             one-cycle pulse, interrupt accepted
//   rseq_done           last word consumed this cycle (combinational)
//   dbl_fault           one-cycle pulse, exception during INTX
//   halted              core halted after a double fault
module rseq_ctrl
  import rseq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       exc_req,
  input  logic [7:0] exc_vec,
  input  logic       int_req,
  input  logic [7:0] int_vec,
  input  logic       if_flag,
  input  logic       instr_boundary,
  input  logic       iret_req,
  input  logic       dec_ready,
  output logic [2:0] rseq_addr,
  output logic       rseq_oe,
  output logic       rseq_active,
  output logic [7:0] rseq_vec,
  output logic       rseq_is_exc,
  output logic       int_ack,
  output logic       rseq_done,
  output logic       dbl_fault,
  output logic       halted
);

  rseq_state_e state_reg, state_next;
  logic [2:0]  addr_reg, addr_next;
  logic [7:0]  vec_reg, vec_next;
  logic        is_exc_reg, is_exc_next;
  logic        int_ack_reg, int_ack_next;
  logic        dbl_fault_reg, dbl_fault_next;
  logic        active_reg;
  logic        halted_reg;
  logic        exc_prev_reg;
  logic        exc_new;
  logic        at_last;

  // exc_req is level-held by its source until rseq_done, so the exception
  // that started the running INTX sequence stays visible throughout it.
  // A "new" exception is therefore either any exc_req while an
  // interrupt-started INTX runs, or a fresh rising edge of exc_req.
  assign exc_new = exc_req && !(is_exc_reg && exc_prev_reg);

  assign at_last = ((state_reg == INTX) && (addr_reg == INTX_LAST)) ||
                   ((state_reg == IRET) && (addr_reg == IRET_LAST));

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    vec_next       = vec_reg;
    is_exc_next    = is_exc_reg;
    int_ack_next   = 1'b0;
    dbl_fault_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (exc_req) begin
          state_next  = INTX;
          addr_next   = INTX_FIRST;
          vec_next    = exc_vec;
          is_exc_next = 1'b1;
        end else if (int_req && if_flag && instr_boundary) begin
          state_next   = INTX;
          addr_next    = INTX_FIRST;
          vec_next     = int_vec;
          is_exc_next  = 1'b0;
          int_ack_next = 1'b1;
        end else if (iret_req && instr_boundary) begin
          state_next = IRET;
          addr_next  = IRET_FIRST;
        end
      end
      INTX: begin
        if (exc_new) begin
          state_next     = HALT;
          addr_next      = INTX_FIRST;
          dbl_fault_next = 1'b1;
        end else if (dec_ready) begin
          if (at_last) begin
            state_next = IDLE;
            addr_next  = INTX_FIRST;
          end else begin
            addr_next = addr_reg + 3'd1;
          end
        end
      end
      IRET: begin
        // A fault while unwinding the stack aborts the IRET and delivers
        // the exception instead.
        if (exc_req) begin
          state_next  = INTX;
          addr_next   = INTX_FIRST;
          vec_next    = exc_vec;
          is_exc_next = 1'b1;
        end else if (dec_ready) begin
          if (at_last) begin
            state_next = IDLE;
            addr_next  = INTX_FIRST;
          end else begin
            addr_next = addr_reg + 3'd1;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= 3'd0;
      vec_reg       <= 8'd0;
      is_exc_reg    <= 1'b0;
      int_ack_reg   <= 1'b0;
      dbl_fault_reg <= 1'b0;
      active_reg    <= 1'b0;
      halted_reg    <= 1'b0;
      exc_prev_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      vec_reg       <= vec_next;
      is_exc_reg    <= is_exc_next;
      int_ack_reg   <= int_ack_next;
      dbl_fault_reg <= dbl_fault_next;
      active_reg    <= (state_next == INTX) || (state_next == IRET);
      halted_reg    <= (state_next == HALT);
      exc_prev_reg  <= exc_req;
    end
  end

  assign rseq_addr   = addr_reg;
  assign rseq_oe     = active_reg;
  assign rseq_active = active_reg;
  assign rseq_vec    = vec_reg;
  assign rseq_is_exc = is_exc_reg;
  assign int_ack     = int_ack_reg;
  assign dbl_fault   = dbl_fault_reg;
  assign halted      = halted_reg;
  assign rseq_done   = active_reg && dec_ready && at_last;

endmodule

// File: tb/tb_rseq_ctrl.sv
// tb_rseq_ctrl
//   Directed-vector bench for rseq_ctrl. Inputs change on the falling edge,
//   outputs are compared 1 ns later, well away from the rising edge.
module tb_rseq_ctrl;
  import rseq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       exc_req;
  logic [7:0] exc_vec;
  logic       int_req;
  logic [7:0] int_vec;
  logic       if_flag;
  logic       instr_boundary;
  logic       iret_req;
  logic       dec_ready;
  logic [2:0] rseq_addr;
  logic       rseq_oe;
  logic       rseq_active;
  logic [7:0] rseq_vec;
  logic       rseq_is_exc;
  logic       int_ack;
  logic       rseq_done;
  logic       dbl_fault;
  logic       halted;

  int n_cmp = 0;
  int n_bad = 0;

  rseq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exc_req        (exc_req),
    .exc_vec        (exc_vec),
    .int_req        (int_req),
    .int_vec        (int_vec),
    .if_flag        (if_flag),
    .instr_boundary (instr_boundary),
    .iret_req       (iret_req),
    .dec_ready      (dec_ready),
    .rseq_addr      (rseq_addr),
    .rseq_oe        (rseq_oe),
    .rseq_active    (rseq_active),
    .rseq_vec       (rseq_vec),
    .rseq_is_exc    (rseq_is_exc),
    .int_ack        (int_ack),
    .rseq_done      (rseq_done),
    .dbl_fault      (dbl_fault),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to the next falling edge and let combinational outputs settle.
  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  // Check the sequencing outputs of the current cycle.
  task automatic check_seq(input string tag, input logic act, input logic [2:0] addr,
                           input logic done);
    check_val({tag, ".active"}, {31'd0, rseq_active}, {31'd0, act});
    check_val({tag, ".oe"},     {31'd0, rseq_oe},     {31'd0, act});
    check_val({tag, ".addr"},   {29'd0, rseq_addr},   {29'd0, addr});
    check_val({tag, ".done"},   {31'd0, rseq_done},   {31'd0, done});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; exc_req = 1'b0; exc_vec = 8'h00; int_req = 1'b0; int_vec = 8'h00;
    if_flag = 1'b0; instr_boundary = 1'b0; iret_req = 1'b0; dec_ready = 1'b0;
    next_cyc();
    // Reset state
    check_seq("rst", 1'b0, 3'd0, 1'b0);
    check_val("rst.vec", {24'd0, rseq_vec}, 32'h0);
    check_val("rst.is_exc", {31'd0, rseq_is_exc}, 32'd0);
    check_val("rst.int_ack", {31'd0, int_ack}, 32'd0);
    check_val("rst.dbl", {31'd0, dbl_fault}, 32'd0);
    check_val("rst.halted", {31'd0, halted}, 32'd0);
    next_cyc();
    rst_n = 1'b1;

    // ---- Test 1: plain interrupt, dec_ready held high
    int_req = 1'b1; int_vec = 8'h20; if_flag = 1'b1; instr_boundary = 1'b1; dec_ready = 1'b1;
    #1;
    check_seq("t1.pre", 1'b0, 3'd0, 1'b0);
    next_cyc();
    int_req = 1'b0;
    check_val("t1.ack", {31'd0, int_ack}, 32'd1);
    check_val("t1.vec", {24'd0, rseq_vec}, 32'h20);
    check_val("t1.is_exc", {31'd0, rseq_is_exc}, 32'd0);
    check_seq("t1.a0", 1'b1, 3'd0, 1'b0);
    next_cyc();
    check_val("t1.ack_low", {31'd0, int_ack}, 32'd0);
    check_seq("t1.a1", 1'b1, 3'd1, 1'b0);
    next_cyc();
    check_seq("t1.a2", 1'b1, 3'd2, 1'b0);
    next_cyc();
    check_seq("t1.a3", 1'b1, 3'd3, 1'b1);
    next_cyc();
    check_seq("t1.idle", 1'b0, 3'd0, 1'b0);

    // ---- Test 2: exception and interrupt together; exception wins
    exc_req = 1'b1; exc_vec = 8'h0E; int_req = 1'b1; int_vec = 8'h21;
    next_cyc();
    check_val("t2.is_exc", {31'd0, rseq_is_exc}, 32'd1);
    check_val("t2.vec", {24'd0, rseq_vec}, 32'h0E);
    check_val("t2.no_ack", {31'd0, int_ack}, 32'd0);
    check_seq("t2.a0", 1'b1, 3'd0, 1'b0);
    next_cyc();
    check_seq("t2.a1", 1'b1, 3'd1, 1'b0);
    next_cyc();
    check_seq("t2.a2", 1'b1, 3'd2, 1'b0);
    next_cyc();
    check_seq("t2.a3", 1'b1, 3'd3, 1'b1);
    check_val("t2.no_dbl_hold", {31'd0, dbl_fault}, 32'd0);
    next_cyc();
    exc_req = 1'b0;
    #1;
    check_seq("t2.gap", 1'b0, 3'd0, 1'b0);
    check_val("t2.gap_dbl", {31'd0, dbl_fault}, 32'd0);
    next_cyc();
    int_req = 1'b0;
    check_val("t2.int_ack", {31'd0, int_ack}, 32'd1);
    check_val("t2.int_vec", {24'd0, rseq_vec}, 32'h21);
    check_val("t2.int_is_exc", {31'd0, rseq_is_exc}, 32'd0);
    check_seq("t2.i0", 1'b1, 3'd0, 1'b0);
    next_cyc();
    next_cyc();
    next_cyc();
    check_seq("t2.i3", 1'b1, 3'd3, 1'b1);
    next_cyc();
    check_seq("t2.idle", 1'b0, 3'd0, 1'b0);

    // ---- Test 3: IRET with dec_ready 1,0,0,1,1
    iret_req = 1'b1;
    next_cyc();
    iret_req = 1'b0; dec_ready = 1'b1;
    #1;
    check_seq("t3.c0", 1'b1, 3'd4, 1'b0);
    check_val("t3.vec_hold", {24'd0, rseq_vec}, 32'h21);
    next_cyc();
    dec_ready = 1'b0; #1;
    check_seq("t3.c1", 1'b1, 3'd5, 1'b0);
    next_cyc();
    check_seq("t3.c2", 1'b1, 3'd5, 1'b0);
    next_cyc();
    dec_ready = 1'b1; #1;
    check_seq("t3.c3", 1'b1, 3'd5, 1'b0);
    next_cyc();
    check_seq("t3.c4", 1'b1, 3'd6, 1'b1);
    next_cyc();
    check_seq("t3.idle", 1'b0, 3'd0, 1'b0);

    // ---- Test 4: interrupt masked by IF
    if_flag = 1'b0; int_req = 1'b1; int_vec = 8'h30;
    next_cyc();
    check_seq("t4.m0", 1'b0, 3'd0, 1'b0);
    check_val("t4.m0_ack", {31'd0, int_ack}, 32'd0);
    next_cyc();
    check_seq("t4.m1", 1'b0, 3'd0, 1'b0);
    if_flag = 1'b1;
    next_cyc();
    int_req = 1'b0;
    check_val("t4.ack", {31'd0, int_ack}, 32'd1);
    check_val("t4.vec", {24'd0, rseq_vec}, 32'h30);
    check_seq("t4.a0", 1'b1, 3'd0, 1'b0);
    next_cyc();
    next_cyc();
    next_cyc();
    check_seq("t4.a3", 1'b1, 3'd3, 1'b1);
    next_cyc();
    check_seq("t4.idle", 1'b0, 3'd0, 1'b0);

    // ---- Test 5: exception aborts IRET, second exception double-faults
    iret_req = 1'b1;
    next_cyc();
    iret_req = 1'b0;
    check_seq("t5.r4", 1'b1, 3'd4, 1'b0);
    next_cyc();
    exc_req = 1'b1; exc_vec = 8'h0D; #1;
    check_seq("t5.r5", 1'b1, 3'd5, 1'b0);
    next_cyc();
    exc_req = 1'b0; #1;
    check_seq("t5.x0", 1'b1, 3'd0, 1'b0);
    check_val("t5.is_exc", {31'd0, rseq_is_exc}, 32'd1);
    check_val("t5.vec", {24'd0, rseq_vec}, 32'h0D);
    next_cyc();
    check_seq("t5.x1", 1'b1, 3'd1, 1'b0);
    next_cyc();
    exc_req = 1'b1; exc_vec = 8'h08; #1;
    check_seq("t5.x2", 1'b1, 3'd2, 1'b0);
    next_cyc();
    check_val("t5.dbl", {31'd0, dbl_fault}, 32'd1);
    check_val("t5.halted", {31'd0, halted}, 32'd1);
    check_val("t5.oe", {31'd0, rseq_oe}, 32'd0);
    check_val("t5.active", {31'd0, rseq_active}, 32'd0);
    next_cyc();
    exc_req = 1'b0; #1;
    check_val("t5.dbl_pulse", {31'd0, dbl_fault}, 32'd0);
    check_val("t5.halted2", {31'd0, halted}, 32'd1);
    next_cyc();
    check_val("t5.halted3", {31'd0, halted}, 32'd1);
    check_val("t5.oe3", {31'd0, rseq_oe}, 32'd0);
    rst_n = 1'b0; #1;
    check_val("t5.rst_halted", {31'd0, halted}, 32'd0);
    check_val("t5.rst_is_exc", {31'd0, rseq_is_exc}, 32'd0);
    next_cyc();
    rst_n = 1'b1;

    // ---- Test 6: asynchronous reset mid-INTX
    int_req = 1'b1; int_vec = 8'h40;
    next_cyc();
    int_req = 1'b0;
    check_seq("t6.a0", 1'b1, 3'd0, 1'b0);
    next_cyc();
    next_cyc();
    check_seq("t6.a2", 1'b1, 3'd2, 1'b0);
    rst_n = 1'b0; #1;
    check_seq("t6.rst", 1'b0, 3'd0, 1'b0);
    check_val("t6.rst_vec", {24'd0, rseq_vec}, 32'h0);
    check_val("t6.rst_ack", {31'd0, int_ack}, 32'd0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    check_seq("t6.after", 1'b0, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
